alu_dispatch_unit: RTL
======================

Name: alu_dispatch_unit

Overview:
- Parametrised, sequential successor to the combinational ALU function decoder.
- Accepts one operation at a time over a valid/ready handshake and decodes `op_fun` into a one-hot unit enable.
- Holds that enable until the selected unit reports done, then returns a result-valid pulse.
- Adds illegal-code detection and a watchdog timeout; sits between the ALU control front-end and the NUM_UNITS execution units (arith, logic, comp, shift, ...).

Parameters:
- NUM_UNITS, 4, number of execution units and the width of the enable/done vectors; valid range 2..16.
- SEL_W, 2, width of `op_fun`; must satisfy 2^SEL_W >= NUM_UNITS.
- TIMEOUT, 15, maximum number of cycles an enable may stay high without a done; 0 disables the watchdog.
- TO_W, 8, width of the watchdog counter; must satisfy TIMEOUT < 2^TO_W.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-low reset, sampled on the CLK rising edge.
- op_valid  input  1  request valid.
- op_fun  input  SEL_W  unit select, sampled when op_valid && op_ready.
- op_ready  output  1  dispatcher can accept a request.
- unit_enable  output  NUM_UNITS  one-hot unit enable (registered).
- unit_done  input  NUM_UNITS  per-unit completion strobe.
- result_valid  output  1  one-cycle pulse: the dispatched unit completed.
- result_unit  output  SEL_W  index of the completed or timed-out unit; valid with result_valid or timeout_err.
- illegal_op  output  1  one-cycle pulse: the accepted `op_fun` was >= NUM_UNITS.
- timeout_err  output  1  one-cycle pulse: the watchdog expired.
- busy  output  1  high while an operation is in flight.

Behaviour:
- Reset:
  - RST low at a rising edge → state = IDLE; unit_enable, result_valid, result_unit, illegal_op, timeout_err, busy and the watchdog counter all cleared to 0.
  - op_ready = 0 while RST is low.
- State machine, two states: IDLE and ACTIVE.
  - op_ready = RST && (state == IDLE), combinational.
  - All other outputs are registered.
- IDLE, accept (op_valid && op_ready at an edge):
  - If op_fun < NUM_UNITS: latch op_fun into sel, go to ACTIVE. From the next cycle: unit_enable = 1 << sel, busy = 1, counter = 0.
  - If op_fun >= NUM_UNITS: illegal_op = 1 for exactly the next cycle, stay in IDLE. No enable is raised and op_ready stays high.
- ACTIVE:
  - unit_enable stays stable and one-hot; op_ready = 0; new op_valid is ignored (not accepted).
  - Counter increments by 1 each cycle; it saturates and does not wrap.
- Completion: unit_done[sel] = 1 at an edge in ACTIVE → at the next cycle:
  - unit_enable = 0, busy = 0;
  - result_valid = 1 for one cycle, result_unit = sel;
  - state = IDLE.
- Other done bits: unit_done bits other than sel are ignored in every state. unit_done in IDLE has no effect.
- Watchdog: TIMEOUT != 0 and counter == TIMEOUT-1 with unit_done[sel] = 0 → at the next cycle:
  - timeout_err = 1 for one cycle, result_unit = sel;
  - unit_enable = 0, busy = 0, state = IDLE, no result_valid.
  - Net effect: the enable is high for exactly TIMEOUT cycles.
- Done vs. timeout: if done and the timeout condition occur in the same cycle, done wins and there is no timeout_err.
- Latency:
  - Request accepted at edge t → enable high from t+1.
  - Earliest done sampled at edge t+1 → result_valid high in cycle t+2, op_ready high in cycle t+2.
  - A new request can be accepted at edge t+2, so the minimum issue interval is 2 cycles.
- Reset mid-operation: at the next edge unit_enable drops to 0; no result_valid and no timeout_err pulse is produced.
- Pulses: result_valid, illegal_op and timeout_err are never high in the same cycle, and each lasts exactly one cycle.

Test Plan:
- Reset, then RST=1 → all outputs 0, op_ready=1. Accept op_fun=2, done[2] 3 cycles after enable rises → unit_enable=4'b0100 for 3 cycles; result_valid pulse with result_unit=2; op_ready back high.
- Back-to-back: op_fun=0 with done[0] high immediately, then op_fun=3 → enables 0001 then 1000; result_valid pulses 2 cycles apart.
- NUM_UNITS=3, SEL_W=2, op_fun=3 → illegal_op one-cycle pulse, unit_enable stays 0, op_ready stays 1.
- TIMEOUT=15, op_fun=1, no done → enable 0010 for exactly 15 cycles, then timeout_err pulse with result_unit=1. Repeat with done[1] on the 15th enable cycle → result_valid, no timeout_err.
- While enable=0001, pulse done[2] and raise op_valid with op_fun=2 → both ignored; enable unchanged, op_ready=0.
- RST low for one edge while enable=0100 → enable 0 at the next edge; no result_valid or timeout_err; op_ready=1 after RST returns high.

Source files
------------

// File: rtl/alu_dispatch_if.sv
// alu_dispatch_if: request/enable/result bundle between the ALU control front-end, the dispatcher and the execution units
//   op_valid/op_fun/op_ready   request handshake from the front-end
//   unit_enable/unit_done      one-hot enable to, and completion strobes from, the execution units
//   result_valid/result_unit   completion report back to the front-end
//   illegal_op/timeout_err     error pulses; busy marks an operation in flight
//   slave modport faces the dispatcher, master modport faces its environment
interface alu_dispatch_if #(
  parameter int NUM_UNITS = 4,
  parameter int SEL_W     = 2
);
  logic                 op_valid;
  logic [SEL_W-1:0]     op_fun;
  logic                 op_ready;
  logic [NUM_UNITS-1:0] unit_enable;
  logic [NUM_UNITS-1:0] unit_done;
  logic                 result_valid;
  logic [SEL_W-1:0]     result_unit;
  logic                 illegal_op;
  logic                 timeout_err;
  logic                 busy;
  modport master (
    output op_valid, op_fun, unit_done,
    input  op_ready, unit_enable, result_valid, result_unit, illegal_op, timeout_err, busy
  );
  modport slave (
    input  op_valid, op_fun, unit_done,
    output op_ready, unit_enable, result_valid, result_unit, illegal_op, timeout_err, busy
  );
endinterface

// File: rtl/alu_dispatch_unit.sv
// alu_dispatch_unit: dispatches one ALU operation at a time to a one-hot unit enable, reports completion, illegal codes and watchdog expiry
//   CLK  rising-edge clock
//   RST  synchronous active-low reset
//   bus  alu_dispatch_if slave: request handshake, unit enable/done, result and error pulses
module alu_dispatch_unit #(
  parameter int NUM_UNITS = 4,
  parameter int SEL_W     = 2,
  parameter int TIMEOUT   = 15,
  parameter int TO_W      = 8
) (
  input logic         CLK,
  input logic         RST,
  alu_dispatch_if.slave bus
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  localparam logic [SEL_W:0]  NUM     = (SEL_W+1)'(NUM_UNITS);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  state_t               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d, ru_q, ru_d;
  logic [NUM_UNITS-1:0] en_q, en_d;
  logic [TO_W-1:0]      cnt_q, cnt_d;
  logic                 rv_q, rv_d, ill_q, ill_d, to_q, to_d, busy_q, busy_d;
  logic                 accept, legal, done_sel, expired;
  assign bus.op_ready     = RST && state_q == IDLE;
  assign bus.unit_enable  = en_q;
  assign bus.result_valid = rv_q;
  assign bus.result_unit  = ru_q;
  assign bus.illegal_op   = ill_q;
  assign bus.timeout_err  = to_q;
  assign bus.busy         = busy_q;
  assign accept   = bus.op_valid && bus.op_ready;
  assign legal    = {1'b0, bus.op_fun} < NUM;
  // en_q is one-hot on sel while active, so masking picks out only the selected unit's done
  assign done_sel = |(bus.unit_done & en_q);
  // counter holds TIMEOUT-1 during the last permitted enable cycle
  assign expired  = TIMEOUT != 0 && cnt_q == TO_LAST;
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ru_d    = ru_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    rv_d    = 1'b0;
    ill_d   = 1'b0;
    to_d    = 1'b0;
    if (state_q == IDLE) begin
      if (accept && legal) begin
        state_d = ACTIVE;
        sel_d   = bus.op_fun;
        en_d    = NUM_UNITS'(1) << bus.op_fun;
        busy_d  = 1'b1;
        cnt_d   = '0;
      end
      ill_d = accept && !legal;
    end else begin
      cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
      // done takes priority over a simultaneous watchdog expiry
      if (done_sel || expired) begin
        state_d = IDLE;
        en_d    = '0;
        busy_d  = 1'b0;
        ru_d    = sel_q;
        rv_d    = done_sel;
        to_d    = !done_sel;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ru_q    <= '0;
      en_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ru_q    <= ru_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      rv_q    <= rv_d;
      ill_q   <= ill_d;
      to_q    <= to_d;
    end
  end
endmodule
